// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port data memory for the accumulator CPU.
// Accepts one MAR/MBR request, waits WAIT_STATES cycles, commits, acks.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] MAR,
  input  logic [15:0] MBR_in,
  input  logic        halt_program,
  output logic [15:0] MBR_out,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            we_q;
  logic            oor_q;
  logic [AW-1:0]   addr_q;
  logic [15:0]     data_q;

  logic            accept;
  logic            in_oor;
  logic            c_en;
  logic            c_we;
  logic            c_oor;
  logic [AW-1:0]   c_addr;
  logic [15:0]     c_data;

  logic [15:0]     mem [DEPTH];

  assign accept = (state == IDLE) && req && !halt_program;
  assign in_oor = {16'h0000, MAR} >= 32'(DEPTH);

  // Select what commits on the edge entering RESP; a zero-wait
  // build commits straight from the live inputs at acceptance.
  always_comb begin
    c_en   = 1'b0;
    c_we   = we_q;
    c_oor  = oor_q;
    c_addr = addr_q;
    c_data = data_q;
    if (accept && (WAIT_STATES == 0)) begin
      c_en   = 1'b1;
      c_we   = we;
      c_oor  = in_oor;
      c_addr = MAR[AW-1:0];
      c_data = MBR_in;
    end else if (state == WAIT && cnt == 4'd1) begin
      c_en   = 1'b1;
    end
  end

  // Storage array: in-range stores only, never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && c_en && c_we && !c_oor) begin
      mem[c_addr] <= c_data;
    end
  end

  // Request FSM with registered ack/err/busy and load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= 16'h0000;
      MBR_out <= 16'h0000;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      if (c_en) begin
        ack <= 1'b1;
        err <= c_oor;
        if (!c_we) begin
          MBR_out <= c_oor ? 16'h0000 : mem[c_addr];
        end
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            we_q   <= we;
            oor_q  <= in_oor;
            addr_q <= MAR[AW-1:0];
            data_q <= MBR_in;
            cnt    <= 4'(WAIT_STATES);
            busy   <= 1'b1;
            state  <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed bench for two builds (2 and 0 waits).
// A timeline model predicts ack/err/busy/MBR_out every cycle.
module tb_data_mem_responder;

  localparam int D = 256;

  logic             clk;
  logic [1:0]       rst, req, we, halt;
  logic [1:0][15:0] mar, din, mbo;
  logic [1:0]       ack, err, busy;

  int nchk = 0;
  int nerr = 0;

  data_mem_responder #(.DEPTH(D), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]),
    .MAR(mar[0]), .MBR_in(din[0]), .halt_program(halt[0]),
    .MBR_out(mbo[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0])
  );

  data_mem_responder #(.DEPTH(D), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]),
    .MAR(mar[1]), .MBR_in(din[1]), .halt_program(halt[1]),
    .MBR_out(mbo[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1])
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  // A request accepted at edge e is acked in the cycle after edge
  // e+WS; it commits on edge e+WS and the block is free after the
  // ack cycle ends.
  bit          live [2];
  bit          pend [2];
  int          ackc [2];
  logic        lw   [2];
  logic [15:0] la   [2];
  logic [15:0] ld   [2];
  logic [15:0] mm   [2][D];
  bit          mk   [2][D];
  logic [15:0] mbr  [2];
  bit          mbk  [2];
  bit          e_ack[2], e_err[2], e_busy[2];

  function automatic void commit(input int i);
    if (la[i] < 16'(D)) begin
      if (lw[i]) begin
        mm[i][la[i][7:0]] = ld[i];
        mk[i][la[i][7:0]] = 1;
      end else begin
        mbr[i] = mm[i][la[i][7:0]];
        mbk[i] = mk[i][la[i][7:0]];
      end
    end else if (!lw[i]) begin
      mbr[i] = 16'h0000;
      mbk[i] = 1;
    end
  endfunction

  initial begin
    int e;
    e = 0;
    for (int i = 0; i < 2; i++) begin
      live[i] = 0; pend[i] = 0; mbk[i] = 0; ackc[i] = 0;
      e_ack[i] = 0; e_err[i] = 0; e_busy[i] = 0;
      for (int a = 0; a < D; a++) mk[i][a] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        int ws;
        bit was;
        ws = (i == 0) ? 2 : 0;
        if (rst[i]) begin
          live[i] = 1;
          pend[i] = 0;
          mbr[i]  = 16'h0000;
          mbk[i]  = 1;
        end else begin
          was = pend[i];
          if (pend[i] && e == ackc[i] - 1) commit(i);
          if (pend[i] && e >= ackc[i]) pend[i] = 0;
          if (!was && req[i] && !halt[i]) begin
            pend[i] = 1;
            ackc[i] = e + 1 + ws;
            lw[i] = we[i];
            la[i] = mar[i];
            ld[i] = din[i];
            if (e == ackc[i] - 1) commit(i);
          end
        end
        e_busy[i] = pend[i];
        e_ack[i]  = pend[i] && (e + 1 == ackc[i]);
        e_err[i]  = e_ack[i] && (la[i] >= 16'(D));
      end
      e++;
    end
  end

  // Per-cycle comparison against the model, away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (live[i]) begin
          chk($sformatf("cmp_ack%0d", i), 32'(ack[i]), 32'(e_ack[i]));
          chk($sformatf("cmp_err%0d", i), 32'(err[i]), 32'(e_err[i]));
          chk($sformatf("cmp_busy%0d", i), 32'(busy[i]),
              32'(e_busy[i]));
          if (mbk[i])
            chk($sformatf("cmp_mbr%0d", i), 32'(mbo[i]), 32'(mbr[i]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called #1 after an edge with the DUT idle; returns #1 after the
  // edge that ends the ack cycle. Inputs are scrambled after accept.
  task automatic op(input int i, input logic w, input logic [15:0] a,
                    input logic [15:0] d, input bit halt_mid,
                    output int lat, output logic e_at,
                    output logic [15:0] m_at);
    req[i] = 1; we[i] = w; mar[i] = a; din[i] = d;
    @(posedge clk); #1;
    req[i] = 0; we[i] = ~w; mar[i] = ~a; din[i] = ~d;
    if (halt_mid) halt[i] = 1;
    lat = 1;
    while (!ack[i] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ack[i]) chk("op_timeout", 32'(lat), 32'(0));
    e_at = err[i];
    m_at = mbo[i];
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat, c, a1, a2, n_ack, n_busy;
    logic        ea;
    logic [15:0] ma;
    rst = 2'b11; req = 0; we = 0; halt = 0; mar = '0; din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 2'b00;
    chk("rst_mbr", 32'(mbo[0]), 32'h0);
    chk("rst_busy", 32'(busy[0]), 32'h0);
    chk("rst_ack", 32'(ack[0]), 32'h0);
    chk("rst_err", 32'(err[0]), 32'h0);

    // Store then load.
    op(0, 1, 16'h0005, 16'hBEEF, 0, lat, ea, ma);
    chk("st_lat", 32'(lat), 32'd3);
    chk("st_err", 32'(ea), 32'h0);
    chk("st_mbr_hold", 32'(ma), 32'h0);
    op(0, 0, 16'h0005, 16'h0000, 0, lat, ea, ma);
    chk("ld_lat", 32'(lat), 32'd3);
    chk("ld_data", 32'(ma), 32'hBEEF);

    // Out of range.
    op(0, 0, 16'h0100, 16'h0000, 0, lat, ea, ma);
    chk("oor_ld_err", 32'(ea), 32'h1);
    chk("oor_ld_mbr", 32'(ma), 32'h0);
    op(0, 1, 16'h0000, 16'h1111, 0, lat, ea, ma);
    op(0, 1, 16'h0100, 16'h1234, 0, lat, ea, ma);
    chk("oor_st_err", 32'(ea), 32'h1);
    op(0, 0, 16'h0000, 16'h0000, 0, lat, ea, ma);
    chk("oor_st_nowrap", 32'(ma), 32'h1111);

    // Held req: loads of 1 then 2.
    op(0, 1, 16'h0001, 16'h0101, 0, lat, ea, ma);
    op(0, 1, 16'h0002, 16'h0202, 0, lat, ea, ma);
    c = 0; a1 = -1; a2 = -1;
    req[0] = 1; we[0] = 0; mar[0] = 16'h0001;
    while (a2 < 0 && c < 30) begin
      @(posedge clk); #1;
      c++;
      if (ack[0]) begin
        if (a1 < 0) begin
          a1 = c;
          chk("held_d1", 32'(mbo[0]), 32'h0101);
          mar[0] = 16'h0002;
        end else begin
          a2 = c;
          req[0] = 0;
          chk("held_d2", 32'(mbo[0]), 32'h0202);
        end
      end
    end
    chk("held_first", 32'(a1), 32'd3);
    chk("held_gap", 32'(a2 - a1), 32'd4);
    @(posedge clk); #1;

    // Halt raised mid-wait, then held with req.
    op(0, 0, 16'h0005, 16'h0000, 1, lat, ea, ma);
    chk("halt_mid_lat", 32'(lat), 32'd3);
    chk("halt_mid_data", 32'(ma), 32'hBEEF);
    req[0] = 1; we[0] = 0; mar[0] = 16'h0001;
    n_ack = 0; n_busy = 0;
    repeat (10) begin
      @(posedge clk); #1;
      n_ack += int'(ack[0]);
      n_busy += int'(busy[0]);
    end
    chk("halt_no_ack", 32'(n_ack), 32'd0);
    chk("halt_no_busy", 32'(n_busy), 32'd0);
    halt[0] = 0;
    c = 0;
    while (!ack[0] && c < 30) begin
      @(posedge clk); #1;
      c++;
    end
    req[0] = 0;
    chk("unhalt_lat", 32'(c), 32'd3);
    chk("unhalt_data", 32'(mbo[0]), 32'h0101);
    @(posedge clk); #1;

    // Reset mid-store.
    op(0, 1, 16'h0007, 16'h5555, 0, lat, ea, ma);
    req[0] = 1; we[0] = 1; mar[0] = 16'h0007; din[0] = 16'hAAAA;
    @(posedge clk); #1;
    req[0] = 0;
    rst[0] = 1;
    @(posedge clk); #1;
    rst[0] = 0;
    chk("rstw_mbr", 32'(mbo[0]), 32'h0);
    chk("rstw_busy", 32'(busy[0]), 32'h0);
    n_ack = 0;
    repeat (6) begin
      @(posedge clk); #1;
      n_ack += int'(ack[0]);
    end
    chk("rstw_no_ack", 32'(n_ack), 32'd0);
    op(0, 0, 16'h0007, 16'h0000, 0, lat, ea, ma);
    chk("rstw_data", 32'(ma), 32'h5555);

    // Zero-wait build.
    op(1, 1, 16'h0001, 16'h00A1, 0, lat, ea, ma);
    chk("z_st_lat", 32'(lat), 32'd1);
    op(1, 1, 16'h0002, 16'h00A2, 0, lat, ea, ma);
    c = 0; a1 = -1; a2 = -1;
    req[1] = 1; we[1] = 0; mar[1] = 16'h0001;
    while (a2 < 0 && c < 30) begin
      @(posedge clk); #1;
      c++;
      if (ack[1]) begin
        if (a1 < 0) begin
          a1 = c;
          chk("z_d1", 32'(mbo[1]), 32'h00A1);
          mar[1] = 16'h0002;
        end else begin
          a2 = c;
          req[1] = 0;
          chk("z_d2", 32'(mbo[1]), 32'h00A2);
        end
      end
    end
    chk("z_first", 32'(a1), 32'd1);
    chk("z_gap", 32'(a2 - a1), 32'd2);
    @(posedge clk); #1;
    op(1, 0, 16'hFFFF, 16'h0000, 0, lat, ea, ma);
    chk("z_oor_err", 32'(ea), 32'h1);
    chk("z_oor_mbr", 32'(ma), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
